pcd_miller_encoder: RTL and testbench
=====================================

PCD_MILLER_ENCODER -- requirements
Module: pcd_miller_encoder

Interface
REQ-001 The module SHALL have one parameter, PAUSE_LEN, default 28: the number of clk cycles pause_n is held low per pause, legal range 8..63.
REQ-002 The module SHALL have port clk, input, 1 bit: the 13.56MHz clock; it runs continuously and is not derived from the field.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active low.
REQ-004 The module SHALL have port data, input, 8 bits: the byte to send, LSb sent first.
REQ-005 The module SHALL have port data_bits, input, 3 bits: the number of valid bits in a byte flagged last; 0 means 8.
REQ-006 The module SHALL have port add_parity, input, 1 bit: sampled with the first byte of a frame; 1 means append odd parity after each full 8-bit byte.
REQ-007 The module SHALL have port valid, input, 1 bit: data, data_bits, last and add_parity are valid.
REQ-008 The module SHALL have port last, input, 1 bit: this byte is the final byte of the frame.
REQ-009 The module SHALL have port ready, output, 1 bit: registered; a byte transfers on a cycle where valid and ready are both 1.
REQ-010 The module SHALL have port pause_n, output, 1 bit: registered; 1 means carrier on, 0 means pause. It drives the PCD modulator or the bench pause_n_async.
REQ-011 The module SHALL have port busy, output, 1 bit: 1 from the start of SOC until the end of EOC.
REQ-012 The module SHALL have port underrun, output, 1 bit: a 1-cycle pulse on frame abort when no next byte is available.

Function
REQ-013 Bit period: 128 clk cycles, counted by a 7-bit counter.
- Sequence Z: pause_n is 0 at period cycles 0..PAUSE_LEN-1.
- Sequence X: pause_n is 0 at cycles 64..63+PAUSE_LEN.
- Sequence Y: pause_n is 1 for the whole period.
REQ-014 Bit encoding:
- logic 1 is X.
- logic 0 is Y if the previous bit was 1, otherwise Z.
- SOC counts as a previous 0.
- A parity bit counts as a previous bit.
REQ-015 Frame: SOC (Z), then data bits LSb first, then a parity bit after each full byte if add_parity is 1, then EOC.
- EOC is a logic 0, encoded per REQ-014, followed by one Y period.
- No parity is sent after a partial last byte, where data_bits is 1..7.
REQ-016 States: IDLE, SOC, DATA, PARITY, EOC0, EOCY.
- IDLE goes to SOC on a transfer.
- SOC goes to DATA after 128 cycles.
- DATA goes to PARITY after the last valid bit if parity is enabled and the byte is full.
- DATA or PARITY goes to DATA (next byte) if the byte was not last and a byte is buffered.
- DATA or PARITY goes to EOC0 if the byte was last.
- EOC0 goes to EOCY after 128 cycles.
- EOCY goes to IDLE after 128 cycles.
REQ-017 Timing: a transfer in IDLE at cycle t starts SOC at cycle t+1, with pause_n 0 on cycles t+1..t+PAUSE_LEN. Every following bit period starts exactly 128 cycles after the previous one, with no gaps.
REQ-018 Buffering: the module has one shift register for the byte being sent plus one holding register.
- ready=1 when the holding register is empty and last has not yet been accepted in the current frame.
- ready is 0 during EOC0 and EOCY.
- ready is 0 in the cycle after a transfer.
REQ-019 Byte handover occurs at the bit-period boundary after the final bit or parity of the current byte. The holding register moves to the shift register in that same cycle.
REQ-020 Underrun: if the handover point is reached with the holding register empty and the current byte not last, the frame ends: the next state is EOC0, underrun pulses for 1 cycle at that boundary, and add_parity/data_bits of an aborted frame are discarded.
REQ-021 A transfer in the same cycle as the handover boundary counts as buffered; that byte is sent without underrun.
REQ-022 Inputs are ignored while ready=0; valid with ready=0 has no effect.
REQ-023 After EOCY the module returns to IDLE with ready=1 on the next cycle. The minimum inter-frame gap is the responsibility of the caller.

Reset
REQ-024 While rst_n=0, outputs SHALL be: pause_n=1, ready=0, busy=0, underrun=0; state=IDLE; counters and buffers cleared.
REQ-025 Reset asserted mid-frame, including mid-pause, SHALL force pause_n=1 immediately (asynchronously). The partial frame is discarded and not resumed.
REQ-026 ready SHALL rise on the first clk edge after rst_n deasserts.

Verification
REQ-027 REQA: data=0x26, data_bits=7, last=1, add_parity=0 -> periods Z Z X X Y Z X Y Z Y (1280 cycles); busy falls at cycle 1281; no parity.
REQ-028 Byte 0x93, last=1, add_parity=1 -> Z, X X Y Z X Y Z X, parity X, EOC Y Y; 12 periods total.
REQ-029 Two bytes 0x93, 0x20 with valid held and add_parity=1 -> byte 2 bit 0 starts exactly 128 cycles after parity 1 starts; ready pulses once per byte; no underrun.
REQ-030 Byte 0x55 with last=0, then valid held low -> after its parity, EOC0/EOCY; underrun=1 for exactly 1 cycle; busy falls 256 cycles later.
REQ-031 data_bits=0 with last=1 sends 8 bits plus parity; data_bits=1 sends 1 bit and no parity.
REQ-032 Assert rst_n=0 at cycle 10 of a Z pause -> pause_n=1 within the same cycle, busy=0; a new frame after release starts with SOC Z.

Source files
------------

// File: rtl/pcd_miller_encoder_if.sv
// Byte-stream handshake into the PCD modified-Miller encoder.
// A byte moves on every clk edge where valid and ready are both 1.
// The producer holds data, data_bits, last and add_parity stable while valid is 1.
// ready is registered by the encoder, and valid has no effect while ready is 0.
interface pcd_miller_encoder_if;
  logic [7:0] data;
  logic [2:0] data_bits;
  logic       add_parity;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (
    output data, data_bits, add_parity, valid, last,
    input  ready
  );

  modport slave (
    input  data, data_bits, add_parity, valid, last,
    output ready
  );
endinterface

// File: rtl/pcd_miller_encoder.sv
// ISO14443-A PCD modified-Miller encoder: serialises bytes into Z/X/Y
// 128-cycle bit periods on pause_n, framed by SOC and EOC.
module pcd_miller_encoder #(
  parameter int PAUSE_LEN = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pcd_miller_encoder_if.slave  bus,
  output logic                 pause_n,
  output logic                 busy,
  output logic                 underrun,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SOC    = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_EOC0   = 3'd4,
    S_EOCY   = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    SEQ_Z = 2'd0,
    SEQ_X = 2'd1,
    SEQ_Y = 2'd2
  } seq_t;

  localparam logic [6:0] PAUSE_END = 7'(PAUSE_LEN);
  localparam logic [6:0] X_START   = 7'd64;
  localparam logic [6:0] X_END     = 7'(64 + PAUSE_LEN);

  state_t     state, state_n;
  seq_t       seq, seq_n;
  logic [6:0] cnt, cnt_n;
  logic [7:0] sh, sh_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [3:0] nbits, nbits_n;
  logic       cur_last, cur_last_n;
  logic       par_acc, par_acc_n;
  logic       par_en, par_en_n;
  logic [7:0] hold_data, hold_data_n;
  logic [3:0] hold_nbits, hold_nbits_n;
  logic       hold_last, hold_last_n;
  logic       hold_full, hold_full_n;
  logic       last_acc, last_acc_n;
  logic       ready_q, ready_n;
  logic       busy_n, underrun_n, pause_n_n;

  logic       xfer, period_end, last_bit, need_parity;
  logic       handover, ho_prev;
  logic [3:0] in_nbits;
  logic       lo_z, lo_x;

  assign bus.ready   = ready_q;
  assign dbg_state   = state;
  assign xfer        = bus.valid & ready_q;
  assign period_end  = (cnt == 7'd127);
  assign last_bit    = ({1'b0, bit_idx} == (nbits - 4'd1));
  assign need_parity = par_en & (nbits == 4'd8);
  // data_bits only applies to a byte flagged last; 0 encodes a full byte
  assign in_nbits    = (bus.last && (bus.data_bits != 3'd0)) ? {1'b0, bus.data_bits} : 4'd8;

  function automatic seq_t enc(input logic b, input logic prev);
    if (b)         return SEQ_X;
    else if (prev) return SEQ_Y;
    else           return SEQ_Z;
  endfunction

  always_comb begin
    state_n      = state;
    seq_n        = seq;
    cnt_n        = (state == S_IDLE) ? 7'd0 : cnt + 7'd1;
    sh_n         = sh;
    bit_idx_n    = bit_idx;
    nbits_n      = nbits;
    cur_last_n   = cur_last;
    par_acc_n    = par_acc;
    par_en_n     = par_en;
    hold_data_n  = hold_data;
    hold_nbits_n = hold_nbits;
    hold_last_n  = hold_last;
    hold_full_n  = hold_full;
    last_acc_n   = last_acc;
    underrun_n   = 1'b0;
    handover     = 1'b0;
    ho_prev      = 1'b0;

    case (state)
      S_IDLE: begin
        if (xfer) begin
          state_n    = S_SOC;
          seq_n      = SEQ_Z;
          sh_n       = bus.data;
          nbits_n    = in_nbits;
          cur_last_n = bus.last;
          bit_idx_n  = 3'd0;
          par_acc_n  = 1'b1;
          par_en_n   = bus.add_parity;
          last_acc_n = bus.last;
        end
      end
      S_SOC: begin
        if (period_end) begin
          state_n = S_DATA;
          seq_n   = enc(sh[0], 1'b0);
        end
      end
      S_DATA: begin
        if (period_end) begin
          par_acc_n = par_acc ^ sh[0];
          if (!last_bit) begin
            sh_n      = sh >> 1;
            bit_idx_n = bit_idx + 3'd1;
            seq_n     = enc(sh[1], sh[0]);
          end else if (need_parity) begin
            state_n = S_PARITY;
            seq_n   = enc(par_acc ^ sh[0], sh[0]);
          end else begin
            handover = 1'b1;
            ho_prev  = sh[0];
          end
        end
      end
      S_PARITY: begin
        // par_acc holds the odd-parity bit being sent in this period
        if (period_end) begin
          handover = 1'b1;
          ho_prev  = par_acc;
        end
      end
      S_EOC0: begin
        if (period_end) begin
          state_n = S_EOCY;
          seq_n   = SEQ_Y;
        end
      end
      S_EOCY: begin
        if (period_end) begin
          state_n     = S_IDLE;
          seq_n       = SEQ_Y;
          hold_full_n = 1'b0;
          last_acc_n  = 1'b0;
          par_en_n    = 1'b0;
        end
      end
      default: begin
        state_n = S_IDLE;
        seq_n   = SEQ_Y;
      end
    endcase

    if (xfer && (state != S_IDLE) && !handover) begin
      hold_data_n  = bus.data;
      hold_nbits_n = in_nbits;
      hold_last_n  = bus.last;
      hold_full_n  = 1'b1;
      last_acc_n   = bus.last;
    end

    // A byte accepted on the boundary edge itself goes straight to the shifter
    if (handover) begin
      if (cur_last) begin
        state_n = S_EOC0;
        seq_n   = enc(1'b0, ho_prev);
      end else if (hold_full) begin
        state_n     = S_DATA;
        seq_n       = enc(hold_data[0], ho_prev);
        sh_n        = hold_data;
        nbits_n     = hold_nbits;
        cur_last_n  = hold_last;
        bit_idx_n   = 3'd0;
        par_acc_n   = 1'b1;
        hold_full_n = 1'b0;
      end else if (xfer) begin
        state_n    = S_DATA;
        seq_n      = enc(bus.data[0], ho_prev);
        sh_n       = bus.data;
        nbits_n    = in_nbits;
        cur_last_n = bus.last;
        bit_idx_n  = 3'd0;
        par_acc_n  = 1'b1;
        last_acc_n = bus.last;
      end else begin
        state_n    = S_EOC0;
        seq_n      = enc(1'b0, ho_prev);
        underrun_n = 1'b1;
      end
    end

    ready_n   = (state_n inside {S_IDLE, S_SOC, S_DATA, S_PARITY}) &&
                !hold_full_n && !last_acc_n && !xfer;
    busy_n    = (state_n != S_IDLE);
    lo_z      = (seq_n == SEQ_Z) && (cnt_n < PAUSE_END);
    lo_x      = (seq_n == SEQ_X) && (cnt_n >= X_START) && (cnt_n < X_END);
    pause_n_n = !(busy_n && (lo_z || lo_x));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      seq        <= SEQ_Y;
      cnt        <= 7'd0;
      sh         <= 8'd0;
      bit_idx    <= 3'd0;
      nbits      <= 4'd0;
      cur_last   <= 1'b0;
      par_acc    <= 1'b0;
      par_en     <= 1'b0;
      hold_data  <= 8'd0;
      hold_nbits <= 4'd0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      last_acc   <= 1'b0;
      ready_q    <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      pause_n    <= 1'b1;
    end else begin
      state      <= state_n;
      seq        <= seq_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      bit_idx    <= bit_idx_n;
      nbits      <= nbits_n;
      cur_last   <= cur_last_n;
      par_acc    <= par_acc_n;
      par_en     <= par_en_n;
      hold_data  <= hold_data_n;
      hold_nbits <= hold_nbits_n;
      hold_last  <= hold_last_n;
      hold_full  <= hold_full_n;
      last_acc   <= last_acc_n;
      ready_q    <= ready_n;
      busy       <= busy_n;
      underrun   <= underrun_n;
      pause_n    <= pause_n_n;
    end
  end

endmodule

// File: tb/tb_pcd_miller_encoder.sv
// Bench for pcd_miller_encoder: directed and random frames compared period by
// period against a bit-level Miller model, plus reset and underrun behaviour.
module tb_pcd_miller_encoder;
  localparam int PAUSE_LEN = 28;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pause_n, busy, underrun;
  logic [2:0] dbg_state;

  pcd_miller_encoder_if bus();

  pcd_miller_encoder #(.PAUSE_LEN(PAUSE_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .pause_n   (pause_n),
    .busy      (busy),
    .underrun  (underrun),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: records pause_n for every busy cycle plus event cycle stamps
  logic obs_q[$];
  logic busy_d = 1'b0;
  bit   fall_seen = 1'b0;
  int   busy_rise_cyc = 0, busy_fall_cyc = 0, und_cnt = 0, und_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_d = 1'b0;
    end else begin
      if (busy) obs_q.push_back(pause_n);
      if (busy && !busy_d) busy_rise_cyc = cyc;
      if (!busy && busy_d) begin
        busy_fall_cyc = cyc;
        fall_seen = 1'b1;
      end
      if (underrun) begin
        und_cnt++;
        und_cyc = cyc;
      end
      busy_d = busy;
    end
  end

  logic [7:0] fr_d[3];
  logic [2:0] fr_db[3];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // letters: 0 = Z, 1 = X, 2 = Y
  function automatic int enc_l(input int b, input int prev);
    if (b != 0) return 1;
    return (prev != 0) ? 2 : 0;
  endfunction

  function automatic logic [127:0] exp_pat(input int l);
    logic [127:0] p;
    for (int c = 0; c < 128; c++)
      p[c] = !((l == 0 && c < PAUSE_LEN) || (l == 1 && c >= 64 && c < 64 + PAUSE_LEN));
    return p;
  endfunction

  task automatic send_byte(input int gap, input logic [7:0] d, input logic [2:0] db,
                           input logic lst, input logic ap, output int xc);
    int waited;
    if (gap > 0) begin
      bus.valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.data = d;
    bus.data_bits = db;
    bus.last = lst;
    bus.add_parity = ap;
    bus.valid = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.ready && waited < 6000);
    check("handshake", bus.ready, 1);
    @(posedge clk);
    #1;
    xc = cyc;
    check("ready_after_xfer", bus.ready, 0);
  endtask

  task automatic run_frame(input int n, input bit ap, input bit abort, input int max_gap);
    int seq[$];
    int prev, ones, nb, b, x0, xc, np, u0, waited;
    logic lst;
    logic [127:0] op;
    seq.delete();
    seq.push_back(0);
    prev = 0;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1) && !abort;
      nb = lst ? ((fr_db[i] == 3'd0) ? 8 : int'(fr_db[i])) : 8;
      ones = 0;
      for (int k = 0; k < nb; k++) begin
        b = int'(fr_d[i][k]);
        seq.push_back(enc_l(b, prev));
        prev = b;
        ones += b;
      end
      if (ap && nb == 8) begin
        b = (ones % 2 == 0) ? 1 : 0;
        seq.push_back(enc_l(b, prev));
        prev = b;
      end
    end
    seq.push_back(enc_l(0, prev));
    seq.push_back(2);
    np = seq.size();

    obs_q.delete();
    fall_seen = 1'b0;
    u0 = und_cnt;
    x0 = 0;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1) && !abort;
      send_byte($urandom_range(max_gap, 0), fr_d[i], fr_db[i], lst, ap, xc);
      if (i == 0) x0 = xc;
    end
    bus.valid = 1'b0;

    if (abort) begin
      waited = 0;
      while (und_cnt == u0 && waited < 6000) begin
        @(posedge clk);
        #2;
        waited++;
      end
      // stray bytes offered during EOC must be ignored
      bus.data = 8'($urandom);
      bus.last = 1'b1;
      bus.valid = 1'b1;
      repeat (64) @(posedge clk);
      #1;
      bus.valid = 1'b0;
    end

    waited = 0;
    while (!fall_seen && waited < 6000) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("busy_fall_seen", fall_seen, 1);
    check("ready_after_eoc", bus.ready, 1);
    check("soc_start_cycle", busy_rise_cyc, x0);
    check("frame_cycles", busy_fall_cyc - x0, np * 128);
    check("obs_len", obs_q.size(), np * 128);
    for (int p = 0; p < np; p++) begin
      for (int c = 0; c < 128; c++)
        op[c] = (p * 128 + c < obs_q.size()) ? obs_q[p * 128 + c] : 1'bx;
      check($sformatf("period%0d", p), op, exp_pat(seq[p]));
    end
    check("underrun_count", und_cnt - u0, abort);
    if (abort) check("eoc_after_underrun", busy_fall_cyc - und_cyc, 256);
  endtask

  initial begin
    int xc;
    bus.valid = 1'b0;
    bus.data = 8'd0;
    bus.data_bits = 3'd0;
    bus.last = 1'b0;
    bus.add_parity = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_pause_n", pause_n, 1);
    check("rst_ready", bus.ready, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", bus.ready, 1);

    // REQA, 7-bit short frame
    fr_d[0] = 8'h26; fr_db[0] = 3'd7;
    run_frame(1, 1'b0, 1'b0, 0);

    // single full byte with parity
    fr_d[0] = 8'h93; fr_db[0] = 3'd0;
    run_frame(1, 1'b1, 1'b0, 2);

    // two bytes back to back with parity
    fr_d[0] = 8'h93; fr_db[0] = 3'd0;
    fr_d[1] = 8'h20; fr_db[1] = 3'd0;
    run_frame(2, 1'b1, 1'b0, 0);

    // underrun after a non-last byte
    fr_d[0] = 8'h55; fr_db[0] = 3'd0;
    run_frame(1, 1'b1, 1'b1, 1);

    // data_bits boundaries
    fr_d[0] = 8'($urandom); fr_db[0] = 3'd0;
    run_frame(1, 1'b1, 1'b0, 1);
    fr_d[0] = 8'($urandom); fr_db[0] = 3'd1;
    run_frame(1, 1'b1, 1'b0, 1);

    // reset in the middle of the SOC pause
    @(posedge clk);
    #1;
    send_byte(0, 8'hA5, 3'd0, 1'b1, 1'b1, xc);
    bus.valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("pause_before_rst", pause_n, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_pause_n", pause_n, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", bus.ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst2", bus.ready, 1);
    fr_d[0] = 8'h3C; fr_db[0] = 3'd0;
    run_frame(1, 1'b0, 1'b0, 1);

    // random frames
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(3, 1);
      for (int i = 0; i < 3; i++) begin
        fr_d[i] = 8'($urandom);
        fr_db[i] = 3'($urandom_range(7, 0));
      end
      run_frame(n, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
